// File: rtl/gpio_periph_if.sv
// CPU data-bus port of the GPIO peripheral: byte address, write data and strobes,
// write request, and the registered read data returned by the slave.
interface gpio_periph_if #(
    parameter int ADDR_W = 10
);
    logic [ADDR_W-1:0] address;
    logic [31:0]       data_in;
    logic [3:0]        width;
    logic              write;
    logic [31:0]       data_out;

    // The bus has no handshake: a write is captured on any rising edge with write=1,
    // and a read returns data one edge after the address is presented.
    modport master (output address, data_in, width, write, input data_out);
    modport slave  (input address, data_in, width, write, output data_out);
endinterface

// File: rtl/gpio_periph.sv
// Memory-mapped GPIO: direction control, atomic set/clear/toggle, synchronised inputs
// and armed rising-edge interrupts with write-1-to-clear sticky status.
module gpio_periph #(
    parameter int                N_PINS      = 8,
    parameter int                ADDR_W      = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 10'h300,
    parameter int                SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    gpio_periph_if.slave      bus,
    input  logic [N_PINS-1:0] gpio_in,
    output logic [N_PINS-1:0] gpio_out,
    output logic [N_PINS-1:0] gpio_oe,
    output logic              irq
);
    localparam int CNT_W = $clog2(SYNC_STAGES + 2);
    localparam logic [CNT_W-1:0] ARM_MAX = CNT_W'(SYNC_STAGES + 1);

    logic [N_PINS-1:0] r_out;
    logic [N_PINS-1:0] r_dir;
    logic [N_PINS-1:0] r_irq_en;
    logic [N_PINS-1:0] r_status;
    logic [N_PINS-1:0] r_sync [SYNC_STAGES];
    logic [N_PINS-1:0] r_prev;
    logic [CNT_W-1:0]  r_arm_cnt;
    logic [31:0]       r_data_out;

    logic              w_sel;
    logic              w_wr;
    logic [2:0]        w_idx;
    logic [31:0]       w_mask;
    logic [31:0]       w_wdata;
    logic [N_PINS-1:0] w_mask_n;
    logic [N_PINS-1:0] w_wd_n;
    logic [N_PINS-1:0] w_sync_out;
    logic              w_armed;
    logic [N_PINS-1:0] w_edge;
    logic [N_PINS-1:0] w_w1c;
    logic [31:0]       w_rdata;
    logic              w_unused;

    assign w_sel      = (bus.address[ADDR_W-1:5] == BASE_ADDR[ADDR_W-1:5]);
    assign w_wr       = w_sel & bus.write;
    assign w_idx      = bus.address[4:2];
    assign w_mask     = {{8{bus.width[3]}}, {8{bus.width[2]}}, {8{bus.width[1]}}, {8{bus.width[0]}}};
    assign w_wdata    = bus.data_in & w_mask;
    assign w_mask_n   = w_mask[N_PINS-1:0];
    assign w_wd_n     = w_wdata[N_PINS-1:0];
    assign w_sync_out = r_sync[SYNC_STAGES-1];
    assign w_unused   = &{1'b0, bus.address[1:0], w_wdata};

    // Pins already high at reset would look like edges until the chain and prev fill.
    assign w_armed = (r_arm_cnt == ARM_MAX);
    assign w_edge  = w_armed ? (w_sync_out & ~r_prev) : '0;
    assign w_w1c   = (w_wr && w_idx == 3'd7) ? w_wd_n : '0;

    always_comb begin
        w_rdata = '0;
        case (w_idx)
            3'd0:    w_rdata[N_PINS-1:0] = r_out;
            3'd4:    w_rdata[N_PINS-1:0] = r_dir;
            3'd5:    w_rdata[N_PINS-1:0] = w_sync_out;
            3'd6:    w_rdata[N_PINS-1:0] = r_irq_en;
            3'd7:    w_rdata[N_PINS-1:0] = r_status;
            default: w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out      <= '0;
            r_dir      <= '0;
            r_irq_en   <= '0;
            r_status   <= '0;
            r_prev     <= '0;
            r_arm_cnt  <= '0;
            r_data_out <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
        end else begin
            r_sync[0] <= gpio_in;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_prev <= w_sync_out;
            if (!w_armed) r_arm_cnt <= r_arm_cnt + CNT_W'(1);
            // Edge set is OR-ed after the clear so a coincident W1C loses.
            r_status <= (r_status & ~w_w1c) | w_edge;
            if (w_wr) begin
                case (w_idx)
                    3'd0:    r_out    <= (r_out & ~w_mask_n) | w_wd_n;
                    3'd1:    r_out    <= r_out | w_wd_n;
                    3'd2:    r_out    <= r_out & ~w_wd_n;
                    3'd3:    r_out    <= r_out ^ w_wd_n;
                    3'd4:    r_dir    <= (r_dir & ~w_mask_n) | w_wd_n;
                    3'd6:    r_irq_en <= (r_irq_en & ~w_mask_n) | w_wd_n;
                    default: ;
                endcase
            end
            r_data_out <= (w_sel && !bus.write) ? w_rdata : '0;
        end
    end

    assign bus.data_out = r_data_out;
    assign gpio_out     = r_out;
    assign gpio_oe      = r_dir;
    assign irq          = |(r_status & r_irq_en);
endmodule

// File: tb/tb_gpio_periph.sv
// Directed bench for gpio_periph: an 8-pin and a 32-pin instance on a shared clock/reset.
module tb_gpio_periph;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  gpio_in8 = '0;
    logic [7:0]  gpio_out8, gpio_oe8;
    logic        irq8;
    logic [31:0] gpio_in32 = '0;
    logic [31:0] gpio_out32, gpio_oe32;
    logic        irq32;
    int          total = 0;
    int          bad = 0;
    logic [31:0] d;

    gpio_periph_if #(.ADDR_W(10)) bus8 ();
    gpio_periph_if #(.ADDR_W(10)) bus32 ();

    gpio_periph #(.N_PINS(8), .ADDR_W(10), .BASE_ADDR(10'h300), .SYNC_STAGES(2)) u8 (
        .clk(clk), .rst_n(rst_n), .bus(bus8),
        .gpio_in(gpio_in8), .gpio_out(gpio_out8), .gpio_oe(gpio_oe8), .irq(irq8));

    gpio_periph #(.N_PINS(32), .ADDR_W(10), .BASE_ADDR(10'h300), .SYNC_STAGES(2)) u32 (
        .clk(clk), .rst_n(rst_n), .bus(bus32),
        .gpio_in(gpio_in32), .gpio_out(gpio_out32), .gpio_oe(gpio_oe32), .irq(irq32));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        bus8.address = '0;  bus8.data_in = '0;  bus8.width = '0;  bus8.write = 1'b0;
        bus32.address = '0; bus32.data_in = '0; bus32.width = '0; bus32.write = 1'b0;
    endtask

    task automatic wr(input bit big, input logic [9:0] a, input logic [31:0] dat, input logic [3:0] w);
        @(negedge clk);
        if (big) begin
            bus32.address = a; bus32.data_in = dat; bus32.width = w; bus32.write = 1'b1;
        end else begin
            bus8.address = a; bus8.data_in = dat; bus8.width = w; bus8.write = 1'b1;
        end
        @(posedge clk);
        #1;
        bus8.write = 1'b0;
        bus32.write = 1'b0;
    endtask

    task automatic rd(input bit big, input logic [9:0] a, output logic [31:0] dat);
        @(negedge clk);
        if (big) begin
            bus32.address = a; bus32.write = 1'b0;
        end else begin
            bus8.address = a; bus8.write = 1'b0;
        end
        @(posedge clk);
        #1;
        dat = big ? bus32.data_out : bus8.data_out;
    endtask

    initial begin
        bus_idle();
        gpio_in8 = 8'hFF;
        repeat (3) @(negedge clk);
        check("rst_gpio_out", {24'h0, gpio_out8}, 32'h0);
        check("rst_gpio_oe", {24'h0, gpio_oe8}, 32'h0);
        check("rst_irq", {31'h0, irq8}, 32'h0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        // Every register zero except IN, which reflects the pins held high
        for (int i = 0; i < 8; i++) begin
            rd(1'b0, 10'(10'h300 + i * 4), d);
            check($sformatf("rst_reg%0d", i), d, (i == 5) ? 32'h0000_00FF : 32'h0);
        end
        check("rst_oe_after", {24'h0, gpio_oe8}, 32'h0);
        check("rst_irq_after", {31'h0, irq8}, 32'h0);
        rd(1'b1, 10'h310, d);
        check("rst_dir32", d, 32'h0);
        gpio_in8 = 8'h00;
        repeat (4) @(negedge clk);

        // Atomic output operations
        wr(1'b0, 10'h300, 32'h0000_00A5, 4'b0001);
        check("out_wr", {24'h0, gpio_out8}, 32'hA5);
        wr(1'b0, 10'h304, 32'h0000_000F, 4'b1111);
        check("out_set", {24'h0, gpio_out8}, 32'hAF);
        rd(1'b0, 10'h300, d);
        check("out_set_rd", d, 32'hAF);
        wr(1'b0, 10'h308, 32'h0000_00F0, 4'b1111);
        check("out_clr", {24'h0, gpio_out8}, 32'h0F);
        wr(1'b0, 10'h30C, 32'h0000_00FF, 4'b1111);
        check("out_tgl", {24'h0, gpio_out8}, 32'hF0);
        wr(1'b0, 10'h300, 32'h0000_00FF, 4'b0010);
        check("out_masked", {24'h0, gpio_out8}, 32'hF0);
        rd(1'b0, 10'h304, d);
        check("set_reads0", d, 32'h0);
        wr(1'b0, 10'h300, 32'hFFFF_FFFF, 4'b1111);
        rd(1'b0, 10'h300, d);
        check("out_upper_bits", d, 32'h0000_00FF);

        // Byte strobes on the wide instance, and an unselected read
        wr(1'b1, 10'h310, 32'hFFFF_FFFF, 4'b0101);
        check("dir32_oe", gpio_oe32, 32'h00FF_00FF);
        rd(1'b1, 10'h310, d);
        check("dir32_rd", d, 32'h00FF_00FF);
        rd(1'b1, 10'h000, d);
        check("unsel_rd", d, 32'h0);

        // Interrupt path with exact latency
        wr(1'b0, 10'h318, 32'h0000_0004, 4'b1111);
        check("irq_idle", {31'h0, irq8}, 32'h0);
        @(negedge clk);
        gpio_in8[2] = 1'b1;
        @(posedge clk); #1;
        check("irq_e0", {31'h0, irq8}, 32'h0);
        @(posedge clk); #1;
        check("irq_e1", {31'h0, irq8}, 32'h0);
        @(posedge clk); #1;
        check("irq_e2", {31'h0, irq8}, 32'h1);
        rd(1'b0, 10'h31C, d);
        check("status_04", d, 32'h04);
        @(negedge clk);
        gpio_in8[3] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("irq_still", {31'h0, irq8}, 32'h1);
        rd(1'b0, 10'h31C, d);
        check("status_0c", d, 32'h0C);
        wr(1'b0, 10'h31C, 32'h0000_0004, 4'b1111);
        check("irq_cleared", {31'h0, irq8}, 32'h0);
        rd(1'b0, 10'h31C, d);
        check("status_08", d, 32'h08);

        // Edge set wins over a coincident W1C on the same bit
        @(negedge clk);
        gpio_in8[5] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        wr(1'b0, 10'h31C, 32'h0000_0020, 4'b1111);
        rd(1'b0, 10'h31C, d);
        check("set_beats_clr", d, 32'h28);
        wr(1'b0, 10'h31C, 32'h0000_0020, 4'b1111);
        rd(1'b0, 10'h31C, d);
        check("w1c_next", d, 32'h08);

        // Output readback through the input path
        wr(1'b0, 10'h310, 32'h0000_0001, 4'b1111);
        check("dir_oe", {24'h0, gpio_oe8}, 32'h01);
        wr(1'b0, 10'h300, 32'h0000_0001, 4'b0001);
        check("out_01", {24'h0, gpio_out8}, 32'h01);
        @(negedge clk);
        gpio_in8 = 8'h01;
        @(posedge clk);
        @(posedge clk);
        rd(1'b0, 10'h314, d);
        check("in_readback", d, 32'h01);
        wr(1'b0, 10'h318, 32'h0000_0008, 4'b1111);
        check("irq_en8", {31'h0, irq8}, 32'h1);
        rd(1'b0, 10'h314, d);
        check("dout_before_rst", d, 32'h01);

        // Asynchronous reset in the middle of a cycle
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out", {24'h0, gpio_out8}, 32'h0);
        check("mid_rst_oe", {24'h0, gpio_oe8}, 32'h0);
        check("mid_rst_irq", {31'h0, irq8}, 32'h0);
        check("mid_rst_dout", bus8.data_out, 32'h0);
        check("mid_rst_oe32", gpio_oe32, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        rd(1'b0, 10'h31C, d);
        check("post_rst_status", d, 32'h0);
        rd(1'b0, 10'h318, d);
        check("post_rst_en", d, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL timeout observed=running expected=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule
